// File: rtl/rx_frame_parse.sv
// Receive frame parser: strips preamble/SFD, filters the destination address, checks CRC-32,
// writes frame bytes into the receive buffer and reports one status pulse per frame.
module rx_frame_parse #(
    parameter int MAXLEN = 1518,
    parameter int MINLEN = 64
) (
    input  logic        rxclk_i,
    input  logic        rst,
    input  logic        rxdv_i,
    input  logic        byte_stb_i,
    input  logic [7:0]  dat_i,
    input  logic        rxer_i,
    input  logic [47:0] mac_i,
    input  logic        promisc_i,
    input  logic        buf_rdy_i,
    output logic        wr_en_o,
    output logic [10:0] wr_addr_o,
    output logic [7:0]  wr_dat_o,
    output logic        done_o,
    output logic [10:0] len_o,
    output logic [4:0]  stat_o,
    output logic        ok_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DROP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_RESID = 32'hDEBB20E3;

    logic [2:0]  state;
    logic [31:0] crc;
    logic [10:0] count;
    logic        da_ok, bc_ok;
    logic        f_nobuf, f_ovf, f_rxer;
    logic [7:0]  mac_byte;
    logic        addr_hit;
    logic        abort, runt, crcerr;
    logic [4:0]  stat_nxt;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        mac_byte = 8'h00;
        case (count[2:0])
            3'd0: mac_byte = mac_i[7:0];
            3'd1: mac_byte = mac_i[15:8];
            3'd2: mac_byte = mac_i[23:16];
            3'd3: mac_byte = mac_i[31:24];
            3'd4: mac_byte = mac_i[39:32];
            3'd5: mac_byte = mac_i[47:40];
            default: mac_byte = 8'h00;
        endcase
    end

    assign addr_hit = (da_ok && dat_i == mac_byte) || (bc_ok && dat_i == 8'hFF) || promisc_i;

    // Aborted frames (no buffer / overflow) report only the abort cause, not length or CRC.
    assign abort    = f_nobuf | f_ovf;
    assign runt     = !abort && (count < 11'(MINLEN));
    assign crcerr   = !abort && (crc != CRC_RESID);
    assign stat_nxt = {f_nobuf, f_ovf, f_rxer, runt, crcerr};

    always_ff @(posedge rxclk_i or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            crc       <= 32'hFFFFFFFF;
            count     <= '0;
            da_ok     <= 1'b0;
            bc_ok     <= 1'b0;
            f_nobuf   <= 1'b0;
            f_ovf     <= 1'b0;
            f_rxer    <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_dat_o  <= '0;
            done_o    <= 1'b0;
            len_o     <= '0;
            stat_o    <= '0;
            ok_o      <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            if (state == S_DATA && rxer_i) f_rxer <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (rxdv_i) begin
                        state   <= S_PRE;
                        crc     <= 32'hFFFFFFFF;
                        count   <= '0;
                        da_ok   <= 1'b1;
                        bc_ok   <= 1'b1;
                        f_nobuf <= 1'b0;
                        f_ovf   <= 1'b0;
                        f_rxer  <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (!rxdv_i) state <= S_IDLE;
                    else if (byte_stb_i && dat_i != 8'h55) begin
                        if (dat_i == 8'hD5 && buf_rdy_i) state <= S_DATA;
                        else begin
                            state   <= S_DROP;
                            f_nobuf <= (dat_i == 8'hD5);
                        end
                    end
                end
                S_DATA: begin
                    // A byte coinciding with the rxdv_i fall is still consumed; DROP overrides DONE.
                    if (!rxdv_i) state <= S_DONE;
                    if (byte_stb_i) begin
                        if (count == 11'(MAXLEN)) begin
                            f_ovf <= 1'b1;
                            state <= S_DROP;
                        end else begin
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= count;
                            wr_dat_o  <= dat_i;
                            crc       <= crc_byte(crc, dat_i);
                            count     <= count + 11'd1;
                            if (count < 11'd6) begin
                                da_ok <= da_ok && (dat_i == mac_byte);
                                bc_ok <= bc_ok && (dat_i == 8'hFF);
                            end
                            if (count == 11'd5 && !addr_hit) state <= S_DROP;
                        end
                    end
                end
                S_DROP: begin
                    if (!rxdv_i) state <= abort ? S_DONE : S_IDLE;
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    len_o  <= count;
                    stat_o <= stat_nxt;
                    ok_o   <= (stat_nxt == 5'b0);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_parse.sv
// Directed bench for rx_frame_parse: builds Ethernet frames with a reference FCS and checks
// buffer writes and end-of-frame status against hand-derived expectations.
module tb_rx_frame_parse;

    logic        rxclk_i = 1'b0;
    logic        rst = 1'b0;
    logic        rxdv_i = 1'b0;
    logic        byte_stb_i = 1'b0;
    logic [7:0]  dat_i = 8'h00;
    logic        rxer_i = 1'b0;
    logic [47:0] mac_i = 48'h01_00_00_00_00_02;
    logic        promisc_i = 1'b0;
    logic        buf_rdy_i = 1'b1;
    logic        wr_en_o;
    logic [10:0] wr_addr_o;
    logic [7:0]  wr_dat_o;
    logic        done_o;
    logic [10:0] len_o;
    logic [4:0]  stat_o;
    logic        ok_o;

    rx_frame_parse dut (
        .rxclk_i(rxclk_i), .rst(rst), .rxdv_i(rxdv_i), .byte_stb_i(byte_stb_i), .dat_i(dat_i),
        .rxer_i(rxer_i), .mac_i(mac_i), .promisc_i(promisc_i), .buf_rdy_i(buf_rdy_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_dat_o(wr_dat_o), .done_o(done_o),
        .len_o(len_o), .stat_o(stat_o), .ok_o(ok_o)
    );

    always #5 rxclk_i = ~rxclk_i;

    logic [7:0]  frm [0:1599];
    int          tests = 0, fails = 0;
    int          wr_tot = 0, wr_base = 0, addr_bad = 0, data_bad = 0, done_tot = 0, cyc = 0;
    int          last_wr_t = 0, last_done_t = 0;
    logic [10:0] cap_len = '0;
    logic [4:0]  cap_stat = '0;
    logic        cap_ok = 1'b0;

    // Write/done monitor, sampled on the inactive edge.
    always @(negedge rxclk_i) begin
        cyc = cyc + 1;
        if (wr_en_o === 1'b1) begin
            if (int'(wr_addr_o) != wr_tot - wr_base) addr_bad = addr_bad + 1;
            if (wr_dat_o !== frm[wr_addr_o]) data_bad = data_bad + 1;
            wr_tot = wr_tot + 1;
            last_wr_t = cyc;
        end
        if (done_o === 1'b1) begin
            done_tot = done_tot + 1;
            cap_len = len_o;
            cap_stat = stat_o;
            cap_ok = ok_o;
            last_done_t = cyc;
        end
    end

    // Bit-serial reference CRC over frm[0..n-1], returned as the on-wire FCS value.
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input int len);
        logic [31:0] fcs;
        for (int i = 0; i < 1600; i++) frm[i] = 8'(i);
        for (int i = 0; i < 6; i++) frm[i] = dst[8*i +: 8];
        for (int i = 6; i < 12; i++) frm[i] = 8'hA0 + 8'(i);
        frm[12] = 8'h08;
        frm[13] = 8'h00;
        fcs = ref_fcs(len - 4);
        for (int k = 0; k < 4; k++) frm[len - 4 + k] = fcs[8*k +: 8];
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge rxclk_i);
        dat_i = b;
        byte_stb_i = 1'b1;
        @(negedge rxclk_i);
        byte_stb_i = 1'b0;
    endtask

    task automatic send_frame(input int n, input int rxer_at, input int rst_at, input bit coinc);
        wr_base = wr_tot;
        @(negedge rxclk_i);
        rxdv_i = 1'b1;
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < n; i++) begin
            @(negedge rxclk_i);
            dat_i = frm[i];
            byte_stb_i = 1'b1;
            rxer_i = (i == rxer_at);
            rst = (i == rst_at);
            if (coinc && i == n - 1) rxdv_i = 1'b0;
            @(negedge rxclk_i);
            byte_stb_i = 1'b0;
            rxer_i = 1'b0;
            rst = 1'b0;
        end
        rxdv_i = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        repeat (3) @(negedge rxclk_i);
        tests++; if (wr_en_o !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en_o); end
        tests++; if (wr_addr_o !== 11'd0) begin fails++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr_o); end
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
        tests++; if (len_o !== 11'd0) begin fails++; $display("FAIL reset_len: got %0d want 0", len_o); end
        tests++; if (stat_o !== 5'b0) begin fails++; $display("FAIL reset_stat: got %b want 00000", stat_o); end
        tests++; if (ok_o !== 1'b0) begin fails++; $display("FAIL reset_ok: got %b want 0", ok_o); end
        rst = 1'b0;
        repeat (2) @(negedge rxclk_i);
    endtask

    task automatic run_check(input string nm, input int n, input int rxer_at, input int rst_at,
                             input int exp_wr, input int exp_done, input int exp_len,
                             input logic [4:0] exp_stat, input logic exp_ok);
        int w0, d0;
        w0 = wr_tot; d0 = done_tot;
        addr_bad = 0; data_bad = 0;
        send_frame(n, rxer_at, rst_at, 1'b0);
        repeat (10) @(negedge rxclk_i);
        tests++; if (wr_tot - w0 != exp_wr) begin fails++; $display("FAIL %s_writes: got %0d want %0d", nm, wr_tot - w0, exp_wr); end
        tests++; if (addr_bad != 0) begin fails++; $display("FAIL %s_addr_seq: got %0d bad want 0", nm, addr_bad); end
        tests++; if (data_bad != 0) begin fails++; $display("FAIL %s_data: got %0d bad want 0", nm, data_bad); end
        tests++; if (done_tot - d0 != exp_done) begin fails++; $display("FAIL %s_done: got %0d want %0d", nm, done_tot - d0, exp_done); end
        if (exp_done != 0) begin
            tests++; if (cap_len !== 11'(exp_len)) begin fails++; $display("FAIL %s_len: got %0d want %0d", nm, cap_len, exp_len); end
            tests++; if (cap_stat !== exp_stat) begin fails++; $display("FAIL %s_stat: got %b want %b", nm, cap_stat, exp_stat); end
            tests++; if (cap_ok !== exp_ok) begin fails++; $display("FAIL %s_ok: got %b want %b", nm, cap_ok, exp_ok); end
            if (exp_wr != 0) begin
                tests++; if (last_done_t <= last_wr_t) begin fails++; $display("FAIL %s_order: done at %0d last write at %0d", nm, last_done_t, last_wr_t); end
            end
        end
    endtask

    task automatic test_good;
        build_frame(48'h01_00_00_00_00_02, 64);
        run_check("good", 64, -1, -1, 64, 1, 64, 5'b00000, 1'b1);
        repeat (5) @(negedge rxclk_i);
        tests++; if (len_o !== 11'd64 || ok_o !== 1'b1) begin fails++; $display("FAIL good_hold: got len %0d ok %b want 64 1", len_o, ok_o); end
    endtask

    task automatic test_crc_err;
        build_frame(48'h01_00_00_00_00_02, 64);
        frm[20] = frm[20] ^ 8'h04;
        run_check("crcerr", 64, -1, -1, 64, 1, 64, 5'b00001, 1'b0);
    endtask

    task automatic test_runt;
        build_frame(48'hFF_FF_FF_FF_FF_FF, 60);
        run_check("runt", 60, -1, -1, 60, 1, 60, 5'b00010, 1'b0);
    endtask

    task automatic test_filter;
        build_frame(48'h02_00_00_00_00_02, 64);
        run_check("filter", 64, -1, -1, 6, 0, 0, 5'b0, 1'b0);
        promisc_i = 1'b1;
        run_check("promisc", 64, -1, -1, 64, 1, 64, 5'b00000, 1'b1);
        promisc_i = 1'b0;
    endtask

    task automatic test_ovf;
        build_frame(48'h01_00_00_00_00_02, 1600);
        run_check("ovf", 1600, -1, -1, 1518, 1, 1518, 5'b01000, 1'b0);
    endtask

    task automatic test_nobuf;
        build_frame(48'h01_00_00_00_00_02, 64);
        buf_rdy_i = 1'b0;
        run_check("nobuf", 64, -1, -1, 0, 1, 0, 5'b10000, 1'b0);
        buf_rdy_i = 1'b1;
    endtask

    task automatic test_rxer;
        build_frame(48'h01_00_00_00_00_02, 64);
        run_check("rxer", 64, 20, -1, 64, 1, 64, 5'b00100, 1'b0);
    endtask

    task automatic test_rst_mid;
        int d0;
        build_frame(48'h01_00_00_00_00_02, 64);
        d0 = done_tot;
        send_frame(64, -1, 30, 1'b0);
        repeat (10) @(negedge rxclk_i);
        tests++; if (done_tot != d0) begin fails++; $display("FAIL rstmid_done: got %0d want 0", done_tot - d0); end
        run_check("after_rst", 64, -1, -1, 64, 1, 64, 5'b00000, 1'b1);
    endtask

    task automatic test_back_to_back;
        int w0, d0;
        build_frame(48'h01_00_00_00_00_02, 64);
        w0 = wr_tot; d0 = done_tot;
        addr_bad = 0; data_bad = 0;
        send_frame(64, -1, -1, 1'b1);
        repeat (2) @(negedge rxclk_i);
        tests++; if (cap_len !== 11'd64 || cap_ok !== 1'b1) begin fails++; $display("FAIL b2b_first: got len %0d ok %b want 64 1", cap_len, cap_ok); end
        send_frame(64, -1, -1, 1'b1);
        repeat (10) @(negedge rxclk_i);
        tests++; if (done_tot - d0 != 2) begin fails++; $display("FAIL b2b_done: got %0d want 2", done_tot - d0); end
        tests++; if (wr_tot - w0 != 128) begin fails++; $display("FAIL b2b_writes: got %0d want 128", wr_tot - w0); end
        tests++; if (addr_bad != 0 || data_bad != 0) begin fails++; $display("FAIL b2b_addr_data: got %0d/%0d bad want 0/0", addr_bad, data_bad); end
        tests++; if (cap_len !== 11'd64 || cap_stat !== 5'b0 || cap_ok !== 1'b1) begin fails++; $display("FAIL b2b_second: got len %0d stat %b ok %b want 64 00000 1", cap_len, cap_stat, cap_ok); end
    endtask

    initial begin
        test_reset;
        test_good;
        test_crc_err;
        test_runt;
        test_filter;
        test_ovf;
        test_nobuf;
        test_rxer;
        test_rst_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
